// File: rtl/biquad_loader_pkg.sv
// Shared constants and types for the biquad coefficient loader:
// coefficient offset table, update-register offset and FSM state encoding.
package biquad_loader_pkg;

    localparam int NCOEFF = 25;
    localparam logic [7:0] UPDATE_OFS = 8'h00;

    // Register offset for each coefficient beat of one biquad, in stream order.
    localparam logic [7:0] COEFF_OFS [NCOEFF] = '{
        8'h04, 8'h04,
        8'h08, 8'h08, 8'h08, 8'h08,
        8'h0C, 8'h0C,
        8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
        8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14,
        8'h18,
        8'h1C
    };

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WRITE    = 3'd2,
        UPDATE   = 3'd3,
        RSTPULSE = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    function automatic logic [7:0] coeff_ofs(input logic [4:0] idx);
        logic [7:0] ofs;
        if (idx < 5'(NCOEFF)) begin
            ofs = COEFF_OFS[idx];
        end else begin
            ofs = 8'h00;
        end
        return ofs;
    endfunction

endpackage

// File: rtl/wb_single_write.sv
// Wishbone single-write master: issues one write per start request and
// reports either completion (ack) or a timeout after ACK_TIMEOUT cycles.
module wb_single_write #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_adr,
    input  logic [31:0] i_dat,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        o_done,
    output logic        o_timeout
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT - 1);

    logic          r_active;
    logic [TW-1:0] r_cnt;
    logic [7:0]    r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_done;
    logic          r_timeout;

    // Bus cycle sequencing: launch, hold until ack or timeout, then release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_adr     <= 8'h00;
            r_dat     <= 32'h0000_0000;
            r_sel     <= 4'h0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (r_active) begin
                if (wb_ack_i) begin
                    r_active <= 1'b0;
                    r_sel    <= 4'h0;
                    r_done   <= 1'b1;
                end else if (r_cnt == LIMIT) begin
                    r_active  <= 1'b0;
                    r_sel     <= 4'h0;
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end else if (i_start) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_adr    <= i_adr;
                r_dat    <= i_dat;
                r_sel    <= 4'hF;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign wb_cyc_o  = r_active;
    assign wb_stb_o  = r_active;
    assign wb_we_o   = r_active;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/biquad_coeff_loader.sv
// Streams 25 coefficients per selected biquad onto a wishbone bus, commits each
// biquad through its update register, then pulses the biquad state reset.
module biquad_coeff_loader
    import biquad_loader_pkg::*;
#(
    parameter int         NUM_BQ       = 2,
    parameter logic [7:0] BQ_STRIDE    = 8'h80,
    parameter int         RESET_CYCLES = 32,
    parameter int         ACK_TIMEOUT  = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [NUM_BQ-1:0] bq_mask_i,
    input  logic [31:0]       coeff_tdata,
    input  logic              coeff_tvalid,
    output logic              coeff_tready,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [7:0]        wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i,
    output logic              bq_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int IW = (NUM_BQ > 1) ? $clog2(NUM_BQ) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t            r_state;
    state_t            r_prev_state;
    state_t            w_next_state;
    logic [NUM_BQ-1:0] r_mask;
    logic [IW-1:0]     r_bq_idx;
    logic [4:0]        r_coeff_idx;
    logic [31:0]       r_data;
    logic [RW-1:0]     r_rst_cnt;
    logic              r_busy;
    logic              r_tready;
    logic              r_done;
    logic              r_bq_rst;
    logic              r_err;

    logic              w_busy;
    logic              w_tready;
    logic              w_done;
    logic              w_bq_rst;
    logic              w_launch;
    logic [7:0]        w_base;
    logic [7:0]        w_adr;
    logic [31:0]       w_dat;
    logic [NUM_BQ-1:0] w_rem_mask;
    logic              w_eng_done;
    logic              w_eng_to;

    function automatic logic [IW-1:0] lowest_set(input logic [NUM_BQ-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NUM_BQ - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_rem_mask = r_mask & ~(NUM_BQ'(1) << r_bq_idx);
    assign w_base     = 8'(r_bq_idx) * BQ_STRIDE;

    // State register; the previous state marks the entry cycle of WRITE/UPDATE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_prev_state <= IDLE;
        end else begin
            r_state      <= w_next_state;
            r_prev_state <= r_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = (|bq_mask_i) ? FETCH : DONE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                if (coeff_tvalid && r_tready) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            WRITE: begin
                if (w_eng_to) begin
                    w_next_state = ERR;
                end else if (w_eng_done) begin
                    w_next_state = (r_coeff_idx == 5'(NCOEFF - 1)) ? UPDATE : FETCH;
                end else begin
                    w_next_state = WRITE;
                end
            end
            UPDATE: begin
                if (w_eng_to) begin
                    w_next_state = ERR;
                end else if (w_eng_done) begin
                    if (|w_rem_mask) begin
                        w_next_state = FETCH;
                    end else begin
                        w_next_state = (RESET_CYCLES == 0) ? DONE : RSTPULSE;
                    end
                end else begin
                    w_next_state = UPDATE;
                end
            end
            RSTPULSE: begin
                if (r_rst_cnt == RW'(RESET_CYCLES - 1)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RSTPULSE;
                end
            end
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode; status flags are taken from the next state so the
    // registered copies line up with the state they describe.
    always_comb begin
        w_busy   = (w_next_state != IDLE) && (w_next_state != DONE) && (w_next_state != ERR);
        w_tready = (w_next_state == FETCH);
        w_done   = (w_next_state == DONE);
        w_bq_rst = (w_next_state == RSTPULSE);
        w_launch = ((r_state == WRITE) || (r_state == UPDATE)) && (r_prev_state != r_state);
        if (r_state == UPDATE) begin
            w_adr = w_base + UPDATE_OFS;
            w_dat = 32'd1;
        end else begin
            w_adr = w_base + coeff_ofs(r_coeff_idx);
            w_dat = r_data;
        end
    end

    // Registered status outputs; err is sticky until the next accepted start.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_busy   <= 1'b0;
            r_tready <= 1'b0;
            r_done   <= 1'b0;
            r_bq_rst <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_busy   <= w_busy;
            r_tready <= w_tready;
            r_done   <= w_done;
            r_bq_rst <= w_bq_rst;
            if ((r_state == IDLE) && start_i) begin
                r_err <= 1'b0;
            end else if (w_next_state == ERR) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Datapath: mask/biquad selection, coefficient index, beat capture, pulse timer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mask      <= '0;
            r_bq_idx    <= '0;
            r_coeff_idx <= 5'd0;
            r_data      <= 32'h0000_0000;
            r_rst_cnt   <= '0;
        end else begin
            r_rst_cnt <= (r_state == RSTPULSE) ? r_rst_cnt + RW'(1) : '0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_mask      <= bq_mask_i;
                        r_bq_idx    <= lowest_set(bq_mask_i);
                        r_coeff_idx <= 5'd0;
                    end
                end
                FETCH: begin
                    if (coeff_tvalid && r_tready) begin
                        r_data <= coeff_tdata;
                    end
                end
                WRITE: begin
                    if (w_eng_done) begin
                        r_coeff_idx <= r_coeff_idx + 5'd1;
                    end
                end
                UPDATE: begin
                    if (w_eng_done) begin
                        r_mask      <= w_rem_mask;
                        r_bq_idx    <= lowest_set(w_rem_mask);
                        r_coeff_idx <= 5'd0;
                    end
                end
                default: begin
                    r_coeff_idx <= r_coeff_idx;
                end
            endcase
        end
    end

    wb_single_write #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_single_write (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_start   (w_launch),
        .i_adr     (w_adr),
        .i_dat     (w_dat),
        .wb_ack_i  (wb_ack_i),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .o_done    (w_eng_done),
        .o_timeout (w_eng_to)
    );

    assign coeff_tready = r_tready;
    assign bq_rst_o     = r_bq_rst;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Scoreboard bench for biquad_coeff_loader: expected bus writes are queued by
// the stimulus and checked by an independent monitor as acks complete.
module tb_biquad_coeff_loader;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i;
    logic [1:0]  bq_mask_i;
    logic [31:0] coeff_tdata;
    logic        coeff_tvalid;
    logic        coeff_tready;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        bq_rst_o, busy_o, done_o, err_o;

    biquad_coeff_loader dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .start_i      (start_i),
        .bq_mask_i    (bq_mask_i),
        .coeff_tdata  (coeff_tdata),
        .coeff_tvalid (coeff_tvalid),
        .coeff_tready (coeff_tready),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_ack_i     (wb_ack_i),
        .bq_rst_o     (bq_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] exp_q[$];
    logic [31:0] src_q[$];
    logic [7:0]  ofs_tab[25];
    int          gap = 0;
    int          beats = 0;
    int          wr_started = 0;
    int          withhold_idx = -1;
    int          n_writes = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue the stream for one load and the writes it should produce (first 'limit').
    task automatic push_load(input logic [1:0] mask, input int first, input int limit);
        int c;
        int n;
        logic [7:0] base;
        c = first;
        n = 0;
        for (int b = 0; b < 2; b++) begin
            if (mask[b]) begin
                base = (b == 1) ? 8'h80 : 8'h00;
                for (int k = 0; k < 25; k++) begin
                    src_q.push_back(32'(c));
                    if (n < limit) exp_q.push_back({base + ofs_tab[k], 32'(c)});
                    n++;
                    c++;
                end
                if (n < limit) exp_q.push_back({base, 32'd1});
                n++;
            end
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        @(posedge wb_clk_i); #1;
        bq_mask_i = m;
        start_i   = 1'b1;
        @(posedge wb_clk_i); #1;
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit found, output int rst_cycles);
        found = 1'b0;
        rst_cycles = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge wb_clk_i);
            if (bq_rst_o) rst_cycles++;
            if (done_o) found = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, coeff_tready,
                             bq_rst_o, busy_o, done_o, err_o}, 40'h0);
        chk({name, "_adr"}, wb_adr_o, 40'h0);
        chk({name, "_dat"}, wb_dat_o, 40'h0);
    endtask

    // Coefficient source: one beat per handshake, optional idle gap after each.
    initial begin
        bit xfer;
        int gap_cnt;
        gap_cnt = 0;
        coeff_tvalid = 1'b0;
        coeff_tdata  = 32'h0;
        forever begin
            @(negedge wb_clk_i);
            xfer = coeff_tvalid && coeff_tready;
            @(posedge wb_clk_i); #1;
            if (xfer && src_q.size() > 0) begin
                void'(src_q.pop_front());
                beats++;
                gap_cnt = gap;
            end
            if (gap_cnt > 0) begin
                coeff_tvalid = 1'b0;
                gap_cnt--;
            end else if (src_q.size() > 0) begin
                coeff_tvalid = 1'b1;
                coeff_tdata  = src_q[0];
            end else begin
                coeff_tvalid = 1'b0;
            end
        end
    end

    // Slave responder: ack one cycle after a cycle starts, unless that write is withheld.
    initial begin
        logic cyc_prev;
        cyc_prev = 1'b0;
        wb_ack_i = 1'b0;
        forever begin
            @(posedge wb_clk_i); #1;
            if (wb_cyc_o && !cyc_prev) wr_started++;
            cyc_prev = wb_cyc_o;
            if (wb_rst_i) wb_ack_i = 1'b0;
            else wb_ack_i = wb_cyc_o && wb_stb_o && !wb_ack_i && (wr_started != withhold_idx);
        end
    end

    // Monitor: every acked write must match the head of the scoreboard.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge wb_clk_i);
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: adr %0h dat %0h, expected none", wb_adr_o, wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_adr", wb_adr_o, e[39:32]);
                    chk("wr_dat", wb_dat_o, e[31:0]);
                    chk("wr_we_sel", {wb_we_o, wb_sel_o}, 40'h1F);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rl[7];
        int idx;
        bit found;
        int rc;
        int cnt;
        int w0;

        rl = '{2, 4, 2, 7, 8, 1, 1};
        idx = 0;
        for (int g = 0; g < 7; g++)
            for (int r = 0; r < rl[g]; r++) begin
                ofs_tab[idx] = 8'(4 * (g + 1));
                idx++;
            end

        wb_rst_i = 1'b1; start_i = 1'b0; bq_mask_i = 2'b00;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk_all_zero("reset");
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        // Both biquads, back-to-back acks; a second start while busy is ignored.
        beats = 0;
        push_load(2'b11, 1, 999);
        do_start(2'b11);
        @(negedge wb_clk_i);
        chk("t1_busy", busy_o, 40'h1);
        do_start(2'b01);
        wait_done(3000, found, rc);
        chk("t1_done_seen", found, 40'h1);
        chk("t1_rst_cycles", rc, 40'd32);
        @(negedge wb_clk_i);
        chk("t1_done_pulse", {done_o, busy_o}, 40'h0);
        chk("t1_pending", exp_q.size(), 40'h0);
        chk("t1_beats", beats, 40'd50);
        chk("t1_writes", n_writes, 40'd52);
        chk("t1_err", err_o, 40'h0);

        // Upper biquad only.
        beats = 0;
        push_load(2'b10, 101, 999);
        do_start(2'b10);
        wait_done(2000, found, rc);
        chk("t2_done_seen", found, 40'h1);
        chk("t2_rst_cycles", rc, 40'd32);
        chk("t2_pending", exp_q.size(), 40'h0);
        chk("t2_beats", beats, 40'd25);

        // Empty mask: no bus activity, done the cycle after start.
        w0 = n_writes;
        do_start(2'b00);
        @(negedge wb_clk_i);
        chk("t3_done", done_o, 40'h1);
        @(negedge wb_clk_i);
        chk("t3_done_end", done_o, 40'h0);
        repeat (3) @(negedge wb_clk_i);
        chk("t3_no_writes", n_writes - w0, 40'h0);

        // Ack withheld on the third write: bus held ACK_TIMEOUT cycles, then error.
        beats = 0; wr_started = 0; withhold_idx = 3;
        push_load(2'b01, 301, 2);
        do_start(2'b01);
        for (int i = 0; i < 500 && wr_started < 3; i++) @(negedge wb_clk_i);
        chk("t4_third_started", wr_started >= 3, 40'h1);
        cnt = 0;
        while (wb_cyc_o && cnt < 1000) begin
            cnt++;
            @(negedge wb_clk_i);
        end
        chk("t4_hold_cycles", cnt, 40'd255);
        for (int i = 0; i < 5 && !err_o; i++) @(negedge wb_clk_i);
        chk("t4_err", err_o, 40'h1);
        chk("t4_bus_released", {wb_cyc_o, wb_stb_o}, 40'h0);
        repeat (10) @(negedge wb_clk_i);
        chk("t4_err_sticky", {err_o, busy_o, bq_rst_o}, 40'h4);
        chk("t4_beats", beats, 40'd3);
        chk("t4_pending", exp_q.size(), 40'h0);
        src_q.delete();
        withhold_idx = -1;

        // Source with 10-cycle gaps; start also clears the sticky error.
        beats = 0; gap = 10;
        push_load(2'b01, 401, 999);
        do_start(2'b01);
        @(negedge wb_clk_i);
        chk("t5_err_cleared", err_o, 40'h0);
        wait_done(3000, found, rc);
        chk("t5_done_seen", found, 40'h1);
        chk("t5_pending", exp_q.size(), 40'h0);
        chk("t5_beats", beats, 40'd25);
        chk("t5_err", err_o, 40'h0);
        gap = 0;

        // Reset while the tenth write is on the bus, then a clean reload.
        beats = 0; wr_started = 0; withhold_idx = 10;
        push_load(2'b01, 501, 9);
        do_start(2'b01);
        for (int i = 0; i < 500 && wr_started < 10; i++) @(negedge wb_clk_i);
        chk("t6_tenth_started", wr_started >= 10, 40'h1);
        repeat (3) @(negedge wb_clk_i);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk_all_zero("t6_reset");
        chk("t6_pending", exp_q.size(), 40'h0);
        chk("t6_beats", beats, 40'd10);
        src_q.delete();
        withhold_idx = -1;
        repeat (2) @(negedge wb_clk_i);
        chk("t6_no_done", done_o, 40'h0);

        beats = 0;
        push_load(2'b01, 601, 999);
        do_start(2'b01);
        wait_done(2000, found, rc);
        chk("t6_reload_done", found, 40'h1);
        chk("t6_reload_pending", exp_q.size(), 40'h0);
        chk("t6_reload_beats", beats, 40'd25);

        repeat (5) @(negedge wb_clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_loader.md
BIQUAD_COEFF_LOADER -- requirements
Module: biquad_coeff_loader

Interface
REQ-001 The block SHALL have parameter NUM_BQ, default 2, the number of biquads on the bus.
REQ-002 The block SHALL have parameter BQ_STRIDE, default 8'h80, the address stride between biquads.
REQ-003 The block SHALL have parameter RESET_CYCLES, default 32, the bq_rst_o pulse length; 0 disables the pulse.
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 255, the maximum cycles to wait for wb_ack_i.
REQ-005 The block SHALL have port wb_clk_i, input, 1, the only clock.
REQ-006 The block SHALL have port wb_rst_i, input, 1, a synchronous, active-high reset.
REQ-007 The block SHALL have port start_i, input, 1, a one-cycle load request.
REQ-008 The block SHALL have port bq_mask_i, input, NUM_BQ, the biquads to load, sampled on start.
REQ-009 The block SHALL have ports coeff_tdata, coeff_tvalid and coeff_tready: input 32, input 1 and output 1, forming the coefficient stream.
REQ-010 The block SHALL have wishbone master ports wb_cyc_o, wb_stb_o, wb_we_o (1 each), wb_adr_o (8), wb_dat_o (32), wb_sel_o (4) and wb_ack_i (1).
REQ-011 The block SHALL have port bq_rst_o, output, 1, the biquad state reset.
REQ-012 The block SHALL have outputs busy_o, done_o and err_o, 1 bit each, giving status.

Function
REQ-013 The FSM states SHALL be IDLE, FETCH, WRITE, UPDATE, RSTPULSE, DONE and ERR.
REQ-014 In IDLE, start_i=1 with a non-zero mask SHALL latch the mask, select the lowest set bit and go to FETCH; busy_o=1 from the next cycle.
REQ-015 start_i with bq_mask_i=0 SHALL perform no bus writes and SHALL pulse done_o one cycle later.
REQ-016 start_i while busy SHALL be ignored.
REQ-017 Per enabled biquad, exactly 25 coefficients SHALL be consumed in this order of offsets: 0x04 x2, 0x08 x4, 0x0C x2, 0x10 x7, 0x14 x8, 0x18 x1, 0x1C x1.
REQ-018 coeff_tready SHALL be high only in FETCH; a beat transfers when coeff_tready and coeff_tvalid are both high, then the FSM goes to WRITE.
REQ-019 WRITE SHALL set wb_adr_o = bq_idx*BQ_STRIDE + offset (mod 256) with the data held stable, and wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF.
REQ-020 wb_cyc_o and wb_stb_o SHALL deassert on the cycle after wb_ack_i is sampled high; the next transaction SHALL start no earlier than one idle cycle later.
REQ-021 After the 25th ack, UPDATE SHALL write 32'd1 to bq_idx*BQ_STRIDE + 0x00, then advance to the next set mask bit (FETCH) or, if none remain, to RSTPULSE.
REQ-022 RSTPULSE SHALL drive bq_rst_o high for exactly RESET_CYCLES cycles, or skip the state if RESET_CYCLES=0; the FSM then goes to DONE.
REQ-023 DONE SHALL pulse done_o for one cycle and return to IDLE with busy_o=0.
REQ-024 If wb_ack_i stays low for ACK_TIMEOUT cycles in WRITE or UPDATE, the block SHALL drop the bus next cycle and go to ERR.
REQ-025 ERR SHALL set err_o (sticky), keep bq_rst_o low and return to IDLE; err_o SHALL clear on the next accepted start.
REQ-026 coeff_tvalid low in FETCH SHALL stall indefinitely with no timeout.

Reset
REQ-027 wb_rst_i SHALL force IDLE and drive low every output (wb_*_o, coeff_tready, bq_rst_o, busy_o, done_o, err_o), with wb_adr_o/wb_dat_o at 0.
REQ-028 A reset mid-transaction SHALL abort the bus cycle on the next edge, with no completion or done pulse.

Structure
REQ-029 The offset table (25 entries), NCOEFF=25, the UPDATE offset 0x00 and the FSM state enum SHALL live in package biquad_loader_pkg.
REQ-030 The wishbone single-write engine with timeout SHALL be sub-module wb_single_write.

Verification
REQ-031 Mask 2'b11, 50 coefficients 1..50, ack one cycle later -> writes to 0x04,0x04,0x08..0x1C then 0x00=1, then 0x84..0x9C then 0x80=1; 52 writes; bq_rst_o high 32 cycles; done_o pulse.
REQ-032 Mask 2'b10 -> only 0x84..0x9C and 0x80 are written; 25 beats consumed.
REQ-033 Mask 0 -> zero writes; done_o one cycle after start.
REQ-034 Ack withheld on write 3 for 255 cycles -> bus released; err_o=1 and remains high until the next start.
REQ-035 coeff_tvalid gaps of 10 cycles -> identical write sequence, no error.
REQ-036 wb_rst_i during the 10th write -> all outputs 0 next cycle; a subsequent start reloads correctly from offset 0x04.
